// File: rtl/fir_coef_pkg.sv
// Shared state encoding and register bit positions for the FIR coefficient loader.
package fir_coef_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_ARM} state_e;

  localparam int GO_BIT  = 31;
  localparam int BUSY    = 0;
  localparam int DONE    = 1;
  localparam int ERR     = 2;
  localparam int OVR     = 3;
  localparam int CNT_LSB = 8;
endpackage

// File: rtl/fir_coef_rd_pipe.sv
// Delay line of {valid, addr} matching staging BRAM read latency, so the
// write strobe and tap address line up with the returned data.
module fir_coef_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int AW     = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o
);
  logic [RD_LAT-1:0]         vld_q;
  logic [RD_LAT-1:0][AW-1:0] addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign addr_o = addr_q[RD_LAT-1];
endmodule

// File: rtl/fir_coef_load_ctrl.sv
// Streams staged FIR taps into the shadow coefficient bank, then swaps banks
// on a frame boundary so the filter never sees a half-written set.
module fir_coef_load_ctrl
  import fir_coef_pkg::*;
#(
  parameter int TAPS_W  = 9,
  parameter int MAX_TAP = 255,
  parameter int RD_LAT  = 2,
  parameter int DATA_W  = 32
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic [31:0]       ctrl_word,
  output logic [TAPS_W-1:0] stage_addr,
  input  logic [DATA_W-1:0] stage_data,
  output logic              coef_we,
  output logic [TAPS_W-1:0] coef_addr,
  output logic [DATA_W-1:0] coef_data,
  output logic              coef_bank,
  input  logic              frame_sync,
  output logic              bank_sel,
  output logic [31:0]       status_word
);
  state_e            state_q, state_d;
  logic              go_q;
  logic [TAPS_W-1:0] n_q, n_d, addr_q, addr_d;
  logic              bank_q, bank_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rd_vld, p_vld;
  logic [TAPS_W-1:0] p_addr, n_in;
  logic              go_evt, n_ok, ctrl_unused;

  assign n_in        = ctrl_word[TAPS_W-1:0];
  assign n_ok        = 32'(n_in) <= 32'(MAX_TAP);
  assign go_evt      = ctrl_word[GO_BIT] ^ go_q;
  assign ctrl_unused = ^ctrl_word[30:TAPS_W];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    rd_vld  = 1'b0;
    case (state_q)
      S_IDLE: if (go_evt) begin
        n_d    = n_in;
        done_d = 1'b0;
        if (!n_ok) begin
          err_d = 1'b1;
        end else begin
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          busy_d  = 1'b1;
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_vld = 1'b1;
        if (addr_q == n_q) state_d = S_DRAIN;
        else               addr_d  = addr_q + 1'b1;
      end
      // Leave DRAIN only once the last tap's write is on the bus.
      S_DRAIN: if (p_vld && p_addr == n_q) state_d = S_ARM;
      S_ARM: if (frame_sync) begin
        bank_d  = ~bank_q;
        cnt_d   = cnt_q + 8'd1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_evt && state_q != S_IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge OPB_Clk) begin
    // History loads during reset too, so leaving reset never looks like a toggle.
    go_q <= ctrl_word[GO_BIT];
    if (OPB_Rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  fir_coef_rd_pipe #(.RD_LAT(RD_LAT), .AW(TAPS_W)) u_rd_pipe (
    .clk_i  (OPB_Clk),
    .rst_i  (OPB_Rst),
    .vld_i  (rd_vld),
    .addr_i (addr_q),
    .vld_o  (p_vld),
    .addr_o (p_addr)
  );

  assign stage_addr  = addr_q;
  assign coef_we     = p_vld;
  assign coef_addr   = p_addr;
  assign coef_data   = p_vld ? stage_data : '0;
  assign bank_sel    = bank_q;
  assign coef_bank   = ~bank_q;
  assign status_word = {16'h0, cnt_q, 4'h0, ovr_q, err_q, done_q, busy_q};
endmodule

// File: doc/fir_coef_load_ctrl.md
# fir_coef_load_ctrl

Sequences reloading of one FIR coefficient pair set (b-pair bank, e.g. b18/b19) in the channelizer. Software stages coefficients in a staging BRAM and then toggles a go bit in a 32-bit software control register. The block streams the taps from staging into the FIR's shadow coefficient bank. It then swaps banks on the next frame boundary, so the filter never runs with a partially written set.

## Interface
Parameters:
- TAPS_W, 9, width of the tap index, staging address and coefficient address
- MAX_TAP, 255, largest legal last-tap index
- RD_LAT, 2, staging BRAM read latency in cycles (1..4)
- DATA_W, 32, coefficient word width (two packed 16-bit coefficients)

Ports:
- OPB_Clk  in  1  the single clock; the block has no other clock
- OPB_Rst  in  1  synchronous, active-high reset
- ctrl_word  in  32  software register: [31] go toggle, [TAPS_W-1:0] last tap index N
- stage_addr  out  TAPS_W  staging BRAM read address
- stage_data  in  DATA_W  staging BRAM read data, valid RD_LAT cycles after the address
- coef_we  out  1  shadow-bank write strobe
- coef_addr  out  TAPS_W  shadow-bank tap address
- coef_data  out  DATA_W  shadow-bank write data
- coef_bank  out  1  bank being written; always ~bank_sel
- frame_sync  in  1  one-cycle start-of-frame pulse from the FIR datapath
- bank_sel  out  1  bank the FIR currently uses
- status_word  out  32  [0] busy, [1] done, [2] range error, [3] overrun, [15:8] swap count mod 256; other bits 0

## Operation
- Go detection: `ctrl_word[31]` is registered every cycle. Any change of value, in either direction, is a go event.
- **IDLE**
  - On a go event, capture N.
  - If N > MAX_TAP: set err, clear done, stay in IDLE.
  - Otherwise: clear done and err, set busy, go to READ.
- **READ**
  - Issue `stage_addr` = 0..N, one address per cycle, then go to DRAIN.
  - A delay line of depth RD_LAT carries valid and address.
  - `coef_we`, `coef_addr` and `coef_data` (= `stage_data`) appear when the delayed valid is set.
- **DRAIN**: wait until the last delayed write has issued, then go to ARM.
- **ARM**
  - Wait for `frame_sync`; only syncs sampled while in ARM count.
  - On a sync: toggle `bank_sel`, increment the swap count, set done, clear busy, return to IDLE.
- A go event outside IDLE is ignored and sets overrun. Overrun clears on the next accepted go.
- Reset values
  - Outputs: `bank_sel`=0, `coef_bank`=1, `coef_we`=0, `stage_addr`=0, `coef_addr`=0, `coef_data`=0, `status_word`=0.
  - Internal: state IDLE, delay line cleared.
  - The go-bit history register loads the current `ctrl_word[31]` during reset, so reset never produces a go event.
- Reset mid-operation: any pending writes are discarded and `bank_sel` returns to 0.
- Counters: the tap counter stops at N and does not wrap. The swap count wraps 255 -> 0.

## Timing
- Go event sampled at cycle 0 -> state READ and `stage_addr`=0 at cycle 1.
- `stage_addr`=k at cycle 1+k.
- Matching `coef_we` for tap k at cycle 1+k+RD_LAT; writes are back-to-back with no gaps.
- DRAIN -> ARM on the cycle after the last `coef_we`.
- `frame_sync` sampled at cycle s while in ARM -> `bank_sel`/`coef_bank` flip, done=1 and busy=0 at cycle s+1.
- A `frame_sync` coincident with the last `coef_we` is ignored.
- `status_word` is registered and updates the cycle after the state change.
- N=0 is legal: one write, then ARM.

## Structure
- Package `fir_coef_pkg` holds:
  - state enum (IDLE, READ, DRAIN, ARM)
  - ctrl bit positions: GO_BIT=31
  - status bit positions: BUSY=0, DONE=1, ERR=2, OVR=3, CNT_LSB=8
- Sub-module `fir_coef_rd_pipe`: an RD_LAT-deep shift register of {valid, addr} that aligns the write strobe with returned staging data.

## Test plan
- **Basic load:** reset; preload staging[k]=32'hA000_0000+k; toggle go with N=7 -> 8 consecutive writes, `coef_addr` 0..7, data A000_0000..A000_0007, `coef_bank`=1 throughout, first write at cycle 3 (RD_LAT=2). Then pulse `frame_sync` -> `bank_sel`=1, `status_word`=32'h0000_0102.
- **Range error:** go with N=300 -> no `coef_we` issued, `status_word[2]`=1, state stays IDLE.
- **Overrun:** second toggle during READ -> load completes unchanged with 8 writes, `status_word[3]`=1; the next accepted go clears it.
- **Sync timing:** `frame_sync` during READ and on the last write cycle -> no swap; the first sync in ARM swaps.
- **Mid-op reset:** assert `OPB_Rst` for 1 cycle during READ at tap 3 -> no further `coef_we`, `bank_sel`=0, `status_word`=0, no spurious go after reset.
- **Wrap and edge case:** 256 loads with N=0 -> swap count wraps to 0, `bank_sel` back to 0.
